// File: rtl/vproc_pkg.sv
// Shared types for the vector pending-write scoreboard.
//   VREG_CNT      : number of architectural vector registers (mask width)
//   PEND_ID_MAX_W : storage width of the ID field; instances with narrower
//                   IDs zero-extend into it
//   pend_entry_t  : one scoreboard slot (valid, owning ID, pending mask)
package vproc_pkg;

    localparam int unsigned VREG_CNT      = 32;
    localparam int unsigned PEND_ID_MAX_W = 8;

    typedef struct packed {
        logic                     valid;
        logic [PEND_ID_MAX_W-1:0] id;
        logic [VREG_CNT-1:0]      mask;
    } pend_entry_t;

endpackage

// File: rtl/vproc_pend_entry.sv
// Single scoreboard slot: stores an instruction ID and its outstanding
// vreg write mask, matches the dispatch and clear IDs against it, and
// applies allocate / partial clear / final clear.
//   clk_i, sync_rst_i    : clock, synchronous active-high reset
//   alloc_i              : load this slot from alloc_id_i / alloc_mask_i
//   disp_id_i            : ID at the dispatch port (duplicate detection)
//   clr_valid_i, clr_*   : write-back clear event
//   valid_o              : slot holds a live instruction
//   disp_match_o         : live slot owns disp_id_i
//   clr_match_o          : live slot owns the clear ID of a valid clear
//   mask_nxt_o           : mask after this cycle's update (feeds pending OR)
module vproc_pend_entry
    import vproc_pkg::*;
#(
    parameter int unsigned ID_W           = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                alloc_i,
    input  logic [ID_W-1:0]     alloc_id_i,
    input  logic [VREG_CNT-1:0] alloc_mask_i,
    input  logic [ID_W-1:0]     disp_id_i,
    input  logic                clr_valid_i,
    input  logic [ID_W-1:0]     clr_id_i,
    input  logic [VREG_CNT-1:0] clr_mask_i,
    input  logic                clr_last_i,
    output logic                valid_o,
    output logic                disp_match_o,
    output logic                clr_match_o,
    output logic [VREG_CNT-1:0] mask_nxt_o
);

    pend_entry_t ent_q, ent_d;

    assign valid_o      = ent_q.valid;
    assign disp_match_o = ent_q.valid && (ent_q.id == PEND_ID_MAX_W'(disp_id_i));
    assign clr_match_o  = ent_q.valid && clr_valid_i &&
                          (ent_q.id == PEND_ID_MAX_W'(clr_id_i));
    assign mask_nxt_o   = ent_d.mask;

    // Allocation only targets free slots and a clear only matches live
    // ones, so the two branches never compete for the same slot.
    always_comb begin
        ent_d = ent_q;
        if (alloc_i) begin
            ent_d.valid = 1'b1;
            ent_d.id    = PEND_ID_MAX_W'(alloc_id_i);
            ent_d.mask  = alloc_mask_i;
        end else if (clr_match_o) begin
            ent_d.mask = ent_q.mask & ~clr_mask_i;
            if (clr_last_i) begin
                ent_d.valid = 1'b0;
                ent_d.mask  = '0;
                // The ID of a free slot is never looked at (matches are
                // gated by valid).
                ent_d.id    = DONT_CARE_ZERO ? '0 : 'x;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/vproc_pending_wr_tracker.sv
// Pending vector-register write scoreboard. Records each dispatched
// instruction's write mask under its ID, clears bits as units write back,
// publishes the aggregate pending-write vector and stalls dispatch on
// RAW/WAW overlap, duplicate ID or full table.
//   clk_i, sync_rst_i           : clock, synchronous active-high reset
//   disp_valid_i/disp_ready_o   : dispatch handshake
//   disp_id_i, disp_wr_mask_i,
//   disp_rd_mask_i              : dispatching instruction's ID and vreg masks
//   hazard_o                    : dispatch request overlaps a pending write
//   clr_valid_i, clr_id_i,
//   clr_mask_i, clr_last_i      : write-back clear; last frees the entry
//   pending_o                   : OR of all live entry masks (registered)
//   occupancy_o                 : number of live entries
//   err_o                       : sticky protocol error
module vproc_pending_wr_tracker
    import vproc_pkg::*;
#(
    parameter int unsigned ENTRIES        = 4,
    parameter int unsigned ID_W           = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         sync_rst_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  logic [ID_W-1:0]              disp_id_i,
    input  logic [31:0]                  disp_wr_mask_i,
    input  logic [31:0]                  disp_rd_mask_i,
    output logic                         hazard_o,
    input  logic                         clr_valid_i,
    input  logic [ID_W-1:0]              clr_id_i,
    input  logic [31:0]                  clr_mask_i,
    input  logic                         clr_last_i,
    output logic [31:0]                  pending_o,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy_o,
    output logic                         err_o
);

    localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0]               valid, disp_match, clr_match, alloc;
    logic [ENTRIES-1:0][VREG_CNT-1:0] mask_nxt;
    logic [VREG_CNT-1:0]              pending_q, pending_d;
    logic [OCC_W-1:0]                 occ_q, occ_d;
    logic                             err_q, err_d;
    logic                             full, dup, accept, clr_hit, clr_free;

    // Dispatch side looks only at registered state so ready never depends
    // on a same-cycle clear; a slot freed at t is usable from t+1.
    assign full         = (occ_q == OCC_W'(ENTRIES));
    assign dup          = |disp_match;
    assign hazard_o     = disp_valid_i &&
                          (((disp_rd_mask_i | disp_wr_mask_i) & pending_q) != '0);
    assign disp_ready_o = !full && !hazard_o && !dup;
    assign accept       = disp_valid_i && disp_ready_o;

    // A clear aimed at the ID being allocated this cycle sees no live
    // match, so it falls into the error path naturally.
    assign clr_hit  = |clr_match;
    assign clr_free = clr_hit && clr_last_i;

    // Lowest-index free slot receives the new instruction.
    always_comb begin
        logic taken;
        alloc = '0;
        taken = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!valid[i] && !taken) begin
                alloc[i] = accept;
                taken    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_entry
        vproc_pend_entry #(
            .ID_W           (ID_W),
            .DONT_CARE_ZERO (DONT_CARE_ZERO)
        ) u_entry (
            .clk_i        (clk_i),
            .sync_rst_i   (sync_rst_i),
            .alloc_i      (alloc[g]),
            .alloc_id_i   (disp_id_i),
            .alloc_mask_i (disp_wr_mask_i),
            .disp_id_i    (disp_id_i),
            .clr_valid_i  (clr_valid_i),
            .clr_id_i     (clr_id_i),
            .clr_mask_i   (clr_mask_i),
            .clr_last_i   (clr_last_i),
            .valid_o      (valid[g]),
            .disp_match_o (disp_match[g]),
            .clr_match_o  (clr_match[g]),
            .mask_nxt_o   (mask_nxt[g])
        );
    end

    // Free slots always hold a zero mask, so a plain OR of next-state
    // masks is the OR of live masks.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            pending_d |= mask_nxt[i];
        end
    end

    assign occ_d = occ_q + OCC_W'(accept) - OCC_W'(clr_free);
    assign err_d = err_q || (clr_valid_i && !clr_hit) || (disp_valid_i && dup);

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            pending_q <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

    assign pending_o   = pending_q;
    assign occupancy_o = occ_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vproc_pending_wr_tracker.sv
module tb_vproc_pending_wr_tracker;

    localparam int ENTRIES = 4;

    logic        clk_i = 1'b0;
    logic        sync_rst_i;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [2:0]  disp_id_i;
    logic [31:0] disp_wr_mask_i, disp_rd_mask_i;
    logic        hazard_o;
    logic        clr_valid_i;
    logic [2:0]  clr_id_i;
    logic [31:0] clr_mask_i;
    logic        clr_last_i;
    logic [31:0] pending_o;
    logic [2:0]  occupancy_o;
    logic        err_o;

    vproc_pending_wr_tracker #(.ENTRIES(ENTRIES), .ID_W(3), .DONT_CARE_ZERO(1'b1)) dut (
        .clk_i(clk_i), .sync_rst_i(sync_rst_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_id_i(disp_id_i), .disp_wr_mask_i(disp_wr_mask_i),
        .disp_rd_mask_i(disp_rd_mask_i), .hazard_o(hazard_o),
        .clr_valid_i(clr_valid_i), .clr_id_i(clr_id_i),
        .clr_mask_i(clr_mask_i), .clr_last_i(clr_last_i),
        .pending_o(pending_o), .occupancy_o(occupancy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model indexed by instruction ID (IDs are unique while live).
    bit          m_live [8];
    logic [31:0] m_mask [8];
    bit          m_err;

    bit s_ready, s_hazard;

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int i = 0; i < 8; i++) if (m_live[i]) p |= m_mask[i];
        return p;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_live[i]);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        return disp_valid_i && (((disp_rd_mask_i | disp_wr_mask_i) & m_pend()) != 0);
    endfunction

    function automatic bit m_ready();
        return (m_cnt() < ENTRIES) && !m_hazard() && !m_live[disp_id_i];
    endfunction

    task automatic model_step();
        bit acc, dup;
        if (sync_rst_i) begin
            for (int i = 0; i < 8; i++) begin m_live[i] = 0; m_mask[i] = '0; end
            m_err = 0;
            return;
        end
        acc = disp_valid_i && m_ready();
        dup = disp_valid_i && m_live[disp_id_i];
        if (dup) m_err = 1;
        if (clr_valid_i) begin
            if (m_live[clr_id_i]) begin
                m_mask[clr_id_i] &= ~clr_mask_i;
                if (clr_last_i) begin m_live[clr_id_i] = 0; m_mask[clr_id_i] = '0; end
            end else begin
                m_err = 1;
            end
        end
        if (acc) begin
            m_live[disp_id_i] = 1;
            m_mask[disp_id_i] = disp_wr_mask_i;
        end
    endtask

    // Inputs are driven at posedge+1; outputs compared at posedge+4.
    task automatic cycle(input bit do_chk);
        #3;
        s_ready  = disp_ready_o;
        s_hazard = hazard_o;
        if (do_chk) begin
            chk("ready",   {31'b0, disp_ready_o}, {31'b0, m_ready()});
            chk("hazard",  {31'b0, hazard_o},     {31'b0, m_hazard()});
            chk("pending", pending_o,             m_pend());
            chk("occ",     {29'b0, occupancy_o},  m_cnt());
            chk("err",     {31'b0, err_o},        {31'b0, m_err});
            if (occupancy_o > 3'(ENTRIES)) chk("occ_bound", {29'b0, occupancy_o}, ENTRIES);
        end
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic idle();
        sync_rst_i = 0; disp_valid_i = 0; disp_id_i = 3'd7;
        disp_wr_mask_i = '0; disp_rd_mask_i = '0;
        clr_valid_i = 0; clr_id_i = '0; clr_mask_i = '0; clr_last_i = 0;
    endtask

    task automatic do_reset();
        idle(); sync_rst_i = 1;
        cycle(1);
        sync_rst_i = 0;
    endtask

    function automatic logic [31:0] sparse();
        return $urandom & $urandom & $urandom & $urandom;
    endfunction

    typedef struct {
        bit dv; logic [2:0] did; logic [31:0] wr; logic [31:0] rd;
        bit cv; logic [2:0] cid; logic [31:0] cm; bit cl;
        bit e_rdy; bit e_haz; logic [31:0] e_pend; int e_occ; bit e_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // dv did wr rd | cv cid cm cl | rdy haz pend(next) occ(next) err(next)
        tbl[0] = '{1, 3'd1, 32'hF0,   32'h0,  0, 3'd0, 32'h0,  0, 1, 0, 32'hF0,  1, 0};
        tbl[1] = '{1, 3'd2, 32'h0,    32'h10, 0, 3'd0, 32'h0,  0, 0, 1, 32'hF0,  1, 0};
        tbl[2] = '{1, 3'd2, 32'h0,    32'h10, 1, 3'd1, 32'h10, 0, 0, 1, 32'hE0,  1, 0};
        tbl[3] = '{1, 3'd2, 32'h0,    32'h10, 0, 3'd0, 32'h0,  0, 1, 0, 32'hE0,  2, 0};
        tbl[4] = '{1, 3'd3, 32'h300,  32'h0,  0, 3'd0, 32'h0,  0, 1, 0, 32'h3E0, 3, 0};
        tbl[5] = '{1, 3'd3, 32'h1000, 32'h0,  0, 3'd0, 32'h0,  0, 0, 0, 32'h3E0, 3, 1};
        tbl[6] = '{0, 3'd7, 32'h0,    32'h0,  1, 3'd6, 32'hFFFFFFFF, 1, 1, 0, 32'h3E0, 3, 1};
        tbl[7] = '{1, 3'd0, 32'h1,    32'h0,  1, 3'd1, 32'h0,  1, 1, 0, 32'h301, 3, 1};
        tbl[8] = '{0, 3'd7, 32'h0,    32'h0,  1, 3'd2, 32'h0,  1, 1, 0, 32'h301, 2, 1};

        for (int i = 0; i < 8; i++) begin m_live[i] = 0; m_mask[i] = '0; end
        m_err = 0;
        idle(); sync_rst_i = 1;
        cycle(0);
        do_reset();

        // ---- table vectors ----
        for (int i = 0; i < 9; i++) begin
            idle();
            disp_valid_i = tbl[i].dv; disp_id_i = tbl[i].did;
            disp_wr_mask_i = tbl[i].wr; disp_rd_mask_i = tbl[i].rd;
            clr_valid_i = tbl[i].cv; clr_id_i = tbl[i].cid;
            clr_mask_i = tbl[i].cm; clr_last_i = tbl[i].cl;
            cycle(1);
            chk($sformatf("tbl%0d_ready", i),  {31'b0, s_ready},  {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_hazard", i), {31'b0, s_hazard}, {31'b0, tbl[i].e_haz});
            chk($sformatf("tbl%0d_pend", i),   pending_o,         tbl[i].e_pend);
            chk($sformatf("tbl%0d_occ", i),    {29'b0, occupancy_o}, tbl[i].e_occ);
            chk($sformatf("tbl%0d_err", i),    {31'b0, err_o},    {31'b0, tbl[i].e_err});
        end

        // ---- full table, same-cycle final clear does not open dispatch ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); disp_valid_i = 1; disp_id_i = 3'(i);
            disp_wr_mask_i = 32'hF << (4 * i);
            cycle(1);
        end
        idle(); disp_valid_i = 1; disp_id_i = 3'd4; disp_wr_mask_i = 32'h1_0000;
        clr_valid_i = 1; clr_id_i = 3'd0; clr_last_i = 1;
        cycle(1);
        chk("full_clr_ready", {31'b0, s_ready}, 32'd0);
        chk("full_clr_occ", {29'b0, occupancy_o}, 32'd3);
        clr_valid_i = 0; clr_last_i = 0;
        cycle(1);
        chk("freed_ready", {31'b0, s_ready}, 32'd1);
        chk("freed_pend", pending_o, 32'h1FFF0);
        chk("freed_occ", {29'b0, occupancy_o}, 32'd4);

        // ---- clear targeting the ID allocated in the same cycle ----
        idle(); clr_valid_i = 1; clr_id_i = 3'd4; clr_last_i = 1;
        cycle(1);
        chk("pre_err", {31'b0, err_o}, 32'd0);
        idle(); disp_valid_i = 1; disp_id_i = 3'd5; disp_wr_mask_i = 32'h1;
        clr_valid_i = 1; clr_id_i = 3'd5; clr_mask_i = 32'h1; clr_last_i = 1;
        cycle(1);
        chk("samecyc_ready", {31'b0, s_ready}, 32'd1);
        chk("samecyc_pend", pending_o, 32'hFFF1);
        chk("samecyc_err", {31'b0, err_o}, 32'd1);
        idle();
        for (int i = 0; i < 3; i++) cycle(1);
        chk("err_sticky", {31'b0, err_o}, 32'd1);

        // ---- reset with entries live ----
        idle(); clr_valid_i = 1; clr_id_i = 3'd5; clr_last_i = 1;
        cycle(1);
        chk("pre_rst_occ", {29'b0, occupancy_o}, 32'd3);
        do_reset();
        idle(); disp_valid_i = 1; disp_id_i = 3'd1; disp_wr_mask_i = 32'h2;
        #3;
        chk("rst_pend", pending_o, 32'h0);
        chk("rst_occ", {29'b0, occupancy_o}, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_ready", {31'b0, disp_ready_o}, 32'd1);
        #(-0);
        @(posedge clk_i); model_step(); #1;

        // ---- randomized against the model ----
        for (int n = 0; n < 1500; n++) begin
            int live_q[$];
            idle();
            sync_rst_i = ($urandom_range(0, 79) == 0);
            disp_valid_i = ($urandom_range(0, 3) != 0);
            disp_id_i = 3'($urandom_range(0, 7));
            disp_wr_mask_i = sparse();
            disp_rd_mask_i = sparse();
            clr_valid_i = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 8; i++) if (m_live[i]) live_q.push_back(i);
            if (live_q.size() > 0 && $urandom_range(0, 15) != 0)
                clr_id_i = 3'(live_q[$urandom_range(0, live_q.size() - 1)]);
            else
                clr_id_i = 3'($urandom_range(0, 7));
            clr_mask_i = ($urandom_range(0, 1) == 1) ? m_mask[clr_id_i] : sparse();
            clr_last_i = ($urandom_range(0, 2) == 0);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vproc_pending_wr_tracker.md
Name: vproc_pending_wr_tracker

Overview:
Scoreboard that consumes the per-instruction vector-register write masks generated at decode and tracks them until the owning unit retires its writes.
- On dispatch it records the mask under the instruction ID.
- On unit write-back it clears bits, partially or fully, by ID.
- It publishes the aggregate pending-write vector and a RAW/WAW hazard stall for the instruction at the dispatch port.
- It sits between the decode/dispatch stage and the execution units (LSU, ALU, ELEM, ...).

Parameters:
ENTRIES, 4, number of in-flight instructions tracked (2..8)
ID_W, 3, instruction ID width; 2**ID_W >= ENTRIES
DONT_CARE_ZERO, 1'b0, drive don't-care values to zero instead of 'x

Ports:
clk_i  input  1  clock
sync_rst_i  input  1  synchronous active-high reset
disp_valid_i  input  1  dispatch request
disp_ready_o  output  1  dispatch accepted when valid and ready are both high
disp_id_i  input  ID_W  instruction ID of the dispatch request
disp_wr_mask_i  input  32  vregs the instruction writes (decode pending-write mask)
disp_rd_mask_i  input  32  vregs the instruction reads
hazard_o  output  1  dispatch request overlaps a pending write
clr_valid_i  input  1  write-back / clear event
clr_id_i  input  ID_W  ID whose bits are cleared
clr_mask_i  input  32  vregs whose writes have completed
clr_last_i  input  1  final clear for this ID; frees the entry
pending_o  output  32  registered OR of all valid entry masks
occupancy_o  output  $clog2(ENTRIES+1)  number of valid entries
err_o  output  1  sticky protocol-error flag

Behaviour:
- State per entry: valid bit, ID, 32-bit mask.
- Reset: all valid=0, masks=0, pending_o=0, occupancy_o=0, err_o=0. Reset mid-operation discards all entries.
- Derived signals:
  - full = occupancy == ENTRIES.
  - dup = a valid entry has ID == disp_id_i.
  - hazard_o = disp_valid_i && ((disp_rd_mask_i | disp_wr_mask_i) & pending_o) != 0. This is combinational against registered state only; there is no bypass of same-cycle clears.
  - disp_ready_o = !full && !hazard_o && !dup. Combinational, with no dependency on the clr_* inputs.
- Accept at cycle t: allocate the lowest-index free entry; valid=1, id=disp_id_i, mask=disp_wr_mask_i. pending_o includes the mask at t+1, and occupancy increments at t+1.
- Zero write mask (store, xreg-result instruction): the entry is still allocated so that clear-by-ID remains legal.
- Clear at cycle t, with a matching valid entry: mask &= ~clr_mask_i. If clr_last_i=1, the entry is invalidated and its mask zeroed. Effects visible at t+1.
- Clear with no matching valid entry: ignored; err_o set.
- Clearing bits not set in the entry: no effect, no error.
- Simultaneous accept and clear:
  - Both apply in the same cycle; occupancy change = +1 - (clr_last match).
  - A clear whose ID equals the ID being allocated in the same cycle does not match the new entry; it is ignored and sets err_o.
  - When full, a same-cycle clr_last does not make ready high; the freed slot is usable from t+1.
- disp_valid_i && dup: no accept; err_o set.
- err_o is sticky until reset.
- Request stability: disp_valid_i may drop without acceptance; fields may change while not accepted.
- pending_o is recomputed from next-state entry masks and registered, so it equals the OR of the valid masks every cycle after reset.
- Assertions in the bench:
  - occupancy_o never exceeds ENTRIES.
  - pending_o == OR of valid entry masks.

Decomposition:
- vproc_pkg receives:
  - pend_entry_t typedef (valid, id, mask[31:0]).
  - VREG_CNT = 32 localparam.
- One sub-module, vproc_pend_entry: holds a single entry and performs its set/clear/match logic.
- Top level handles: lowest-free priority encode, OR-reduction, occupancy counter, error flag.

Test Plan:
- Reset, then dispatch id=1 wr=0x0000_00F0 rd=0 -> ready=1; pending_o=0x0000_00F0 and occupancy_o=1 next cycle.
- With id=1 pending, dispatch id=2 rd=0x0000_0010 -> hazard_o=1, ready=0. Clear id=1 mask=0x10 last=0 -> pending_o=0xE0 next cycle, id=2 now accepted.
- Fill 4 entries (ids 0-3, disjoint masks), dispatch id=4 -> ready=0 (full). Same cycle clr id=0 last=1 -> ready still 0. Next cycle ready=1, id=4 allocated in index 0.
- Same-cycle dispatch id=5 wr=0x1 and clear id=5 -> entry allocated with mask 0x1; err_o=1 and stays 1.
- Dispatch id=3 while id=3 valid -> ready=0, err_o=1. Clear unknown id=6 -> err_o=1, state unchanged.
- Assert sync_rst_i with 3 entries valid -> next cycle pending_o=0, occupancy_o=0, err_o=0, ready=1.
